inpass4_sync_filter: RTL



---
 rtl/inpass4_sync_filter_pkg.sv | 20 ++
 rtl/inpass4_sync_filter_channel.sv | 80 ++++++++
 rtl/inpass4_sync_filter.sv | 39 +++
 3 files changed

// File: rtl/inpass4_sync_filter_pkg.sv
// -----------------------------------------------------------------------------
// inpass4_sync_filter_pkg
// Shared definitions for the 4-bit input pass BEL (pad -> fabric).
//   - mode_e      : per-channel capture mode held in two config bits
//   - NUM_CH      : number of pad channels
//   - MODE_W      : config bits per channel
// -----------------------------------------------------------------------------
package inpass4_sync_filter_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_BYPASS = 2'b00,  // O follows the pad combinationally
        MODE_REG    = 2'b01,  // single capture flop
        MODE_SYNC   = 2'b10,  // 2-flop synchroniser
        MODE_FILT   = 2'b11   // synchroniser + debounce filter
    } mode_e;

endpackage

// File: rtl/inpass4_sync_filter_channel.sv
// -----------------------------------------------------------------------------
// cus_mux21
// Standard 2:1 config mux cell.
//   A0 : selected when S = 0
//   A1 : selected when S = 1
//   S  : select
//   X  : output
// -----------------------------------------------------------------------------
module cus_mux21 (
    input  logic A0,
    input  logic A1,
    input  logic S,
    output logic X
);

    assign X = S ? A1 : A0;

endmodule

// -----------------------------------------------------------------------------
// inpass_sync_channel
// One pad input channel: capture flop, synchroniser flop, debounce filter and
// a mode-selected output built from three cus_mux21 cells.
//   i_clk   : user clock
//   i_rst_n : asynchronous active-low reset
//   i_d     : pad-side input (asynchronous to i_clk)
//   i_mode  : capture mode (see mode_e)
//   o_q     : fabric-side output
// -----------------------------------------------------------------------------
module inpass_sync_channel
    import inpass4_sync_filter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_d,
    input  logic [MODE_W-1:0] i_mode,
    output logic              o_q
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_1;
    logic             r_2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_f;
    logic             w_lo;
    logic             w_hi;

    // All state runs in every mode so a mode switch needs no warm-up.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_1   <= 1'b0;
            r_2   <= 1'b0;
            r_cnt <= '0;
            r_f   <= 1'b0;
        end else begin
            r_1 <= i_d;
            r_2 <= r_1;
            // Filter accepts r_2 only after DEBOUNCE_CYCLES consecutive
            // disagreeing samples; any agreement restarts the count.
            if (r_2 == r_f) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_f   <= r_2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // mode[0] picks within each pair, mode[1] picks the pair.
    cus_mux21 u_mux_lo (.A0(i_d), .A1(r_1), .S(i_mode[0]), .X(w_lo));
    cus_mux21 u_mux_hi (.A0(r_2), .A1(r_f), .S(i_mode[0]), .X(w_hi));
    cus_mux21 u_mux_o  (.A0(w_lo), .A1(w_hi), .S(i_mode[1]), .X(o_q));

endmodule

// File: rtl/inpass4_sync_filter.sv
// -----------------------------------------------------------------------------
// inpass4_sync_filter
// Input-direction pass BEL for the RAM_IO tile: four pad inputs enter the
// fabric, each with its own capture mode.
//   UserCLK    : user clock
//   RESETn     : asynchronous active-low reset
//   I[3:0]     : pad-side inputs, asynchronous to UserCLK
//   O[3:0]     : fabric-side outputs to the switch matrix
//   ConfigBits : ConfigBits[2k+1:2k] is the mode of channel k
//                (I0_mode=0..1, I1_mode=2..3, I2_mode=4..5, I3_mode=6..7)
// -----------------------------------------------------------------------------
module inpass4_sync_filter
    import inpass4_sync_filter_pkg::*;
#(
    parameter int unsigned NoConfigBits    = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic                    UserCLK,
    input  logic                    RESETn,
    input  logic [NUM_CH-1:0]       I,
    output logic [NUM_CH-1:0]       O,
    input  logic [NoConfigBits-1:0] ConfigBits
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        inpass_sync_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .i_clk   (UserCLK),
            .i_rst_n (RESETn),
            .i_d     (I[k]),
            .i_mode  (ConfigBits[MODE_W*k +: MODE_W]),
            .o_q     (O[k])
        );
    end

endmodule
